rename_reg_file: RTL and testbench
==================================

# rename_reg_file

Parametrised architectural register file with per-register rename tracking for the out-of-order RV32I core. Sits between the instruction unit, the reorder buffer and the load/store buffer. Per register it holds the committed value, a busy bit and the ROB tag of the youngest in-flight writer. It serves READ_PORTS registered operand lookups per cycle with ROB forwarding and global flush on misprediction.

## Interface
- XLEN, 32, data width
- REG_COUNT, 32, architectural registers (power of two); REG_W = $clog2(REG_COUNT)
- ROB_WIDTH, 4, ROB tag width
- READ_PORTS, 2, operand lookup ports (1..4)

Ports:
- clockIn  in  1  single clock, all state updates on rising edge
- resetIn  in  1  asynchronous, active-low reset
- readAddr  in  READ_PORTS*REG_W  operand register indices, port p at slice p
- readDirty  out  READ_PORTS  operand still waiting on ROB
- readDep  out  READ_PORTS*ROB_WIDTH  ROB tag the operand waits on
- readValue  out  READ_PORTS*XLEN  operand value, meaningful when dirty=0
- robQueryTag  out  READ_PORTS*ROB_WIDTH  tag sent to ROB for forwarding
- robQueryReady  in  READ_PORTS  ROB entry at tag has its result
- robQueryValue  in  READ_PORTS*XLEN  that result
- renameValid  in  1  allocate new writer
- renameDest  in  REG_W  destination register
- renameRobId  in  ROB_WIDTH  new writer's tag
- commitValid  in  1  ROB retires a write
- commitDest  in  REG_W  retired destination
- commitValue  in  XLEN  retired value
- commitRobId  in  ROB_WIDTH  retired tag
- flush  in  1  misprediction: drop all rename state
- lsbRegIndex  in  REG_W  load/store buffer index
- lsbRegValue  out  XLEN  committed value at lsbRegIndex

## Operation
- State: value[REG_COUNT], busy[REG_COUNT], tag[REG_COUNT], addrReg[READ_PORTS].
- Register 0: never written, never busy; reads return 0 with dirty=0, any port.
- Rename (renameValid, dest≠0, !flush): tag[dest]←renameRobId, busy[dest]←1.
- Commit (commitValid, dest≠0): value[dest]←commitValue always. busy[dest]←0 only if tag[dest]==commitRobId and no same-cycle rename to dest.
- Same-cycle rename and commit to same dest: value written, busy stays 1, tag = new renameRobId.
- Flush: all busy←0 next edge; a same-cycle rename is discarded; a same-cycle commit still writes value.
- Read port p, from addrReg[p]=r: robQueryTag=readDep=tag[r]. If !busy[r]: dirty=0, value=value[r]. If busy[r] and robQueryReady: dirty=0, value=robQueryValue. Otherwise dirty=1, value=0.
- lsbRegValue = value[lsbRegIndex], combinational; 0 for index 0.

## Timing
- readAddr sampled at edge N into addrReg. Outputs valid combinationally during cycle N+1 from state after edge N: 1-cycle latency.
- Renames/commits presented in cycle N+1 become visible to read outputs at cycle N+2 unless the bypass is enabled.
- ROB forwarding is purely combinational within the cycle.
- Reset (resetIn=0, asynchronous): value, busy, tag and addrReg all cleared. Outputs: readDirty=0, readDep=0, readValue=0, robQueryTag=0, lsbRegValue=0. Reset mid-operation drops all rename state.

## Configuration
- RENAME_RF_COMMIT_BYPASS_EN defined: in cycle N+1, if commitValid, commitDest==addrReg[p]≠0, busy and tag match, then port p gives dirty=0 and value=commitValue. This bypass has priority over ROB forwarding.
- Undefined: no bypass. The read sees the commit one cycle later, or via the ROB if the entry is still ready.

## Structure
- Shared package (rv32i_pkg): XLEN, REG_COUNT, ROB_WIDTH defaults, reg-index typedef, ROB-tag typedef.
- One sub-module, rename_rf_read_port: addrReg flop plus the dirty/forward/bypass mux, instantiated READ_PORTS times via generate.

## Test plan
- Reset then read x5 on both ports -> next cycle dirty=0, value=0, dep=0.
- Rename x5→tag 3; next cycle read x5 with robQueryReady=0 -> dirty=1, dep=3. With robQueryReady=1 and value 0xDEAD -> dirty=0, value=0xDEAD.
- Rename x5→3, then rename x5→7, then commit x5 tag 3 value 0x11 -> busy stays 1, dep=7; lsbRegValue(x5)=0x11.
- Same-cycle rename x6→2 and commit x6 tag 1 value 0x22 -> x6 busy, dep=2, value[x6]=0x22.
- Flush with concurrent rename x7→4 and commit x8 value 0x33 -> all dirty=0 next read, x7 not busy, x8=0x33.
- Rename/commit to x0 with value 0xFF -> read x0 gives dirty=0, value=0. With the bypass macro: commit x9 tag 5 in read cycle -> same-cycle value returned, dirty=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the out-of-order RV32I core. This package holds
//   the default data width, the architectural register count, the ROB tag
//   width and the read-port count. It also holds the register-index and
//   ROB-tag types built from those defaults.
//   Blocks that need other widths override their own parameters. The
//   typedefs here match only the default build.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int DEFAULT_XLEN       = 32;
  localparam int DEFAULT_REG_COUNT  = 32;
  localparam int DEFAULT_ROB_WIDTH  = 4;
  localparam int DEFAULT_READ_PORTS = 2;
  localparam int DEFAULT_REG_W      = $clog2(DEFAULT_REG_COUNT);

  typedef logic [DEFAULT_REG_W-1:0]     reg_idx_t;
  typedef logic [DEFAULT_ROB_WIDTH-1:0] rob_tag_t;
  typedef logic [DEFAULT_XLEN-1:0]      xdata_t;

endpackage : rv32i_pkg

// File: rtl/rename_rf_read_port.sv
// ---------------------------------------------------------------------------
// rename_rf_read_port
//   One operand lookup port of the rename register file. It registers the
//   requested register index. During the following cycle it resolves the
//   operand from the looked-up register state. Resolution order:
//     not busy           -> committed value, clean
//     busy, bypass hit   -> retiring commit value, clean
//     busy, ROB ready    -> ROB forwarded value, clean
//     busy, otherwise    -> dirty, value 0, readDep names the producer
//   The bypass decision is made by the parent and arrives on bypassHit. In
//   the default build bypassHit is tied low.
//
// Ports
//   clockIn, resetIn    clock, asynchronous active-low reset
//   readAddr            register index to look up (sampled on clock edge)
//   addrReg             registered index, used by the parent to look up state
//   regBusy/regTag/regValue  state of register addrReg
//   bypassHit/bypassValue    same-cycle commit match and its value
//   robQueryReady/robQueryValue  ROB answer for robQueryTag
//   readDirty/readDep/readValue  resolved operand
//   robQueryTag         tag sent to the ROB for forwarding
// ---------------------------------------------------------------------------
module rename_rf_read_port
  import rv32i_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int REG_W     = DEFAULT_REG_W,
  parameter int ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic [REG_W-1:0]     readAddr,
  output logic [REG_W-1:0]     addrReg,
  input  logic                 regBusy,
  input  logic [ROB_WIDTH-1:0] regTag,
  input  logic [XLEN-1:0]      regValue,
  input  logic                 bypassHit,
  input  logic [XLEN-1:0]      bypassValue,
  input  logic                 robQueryReady,
  input  logic [XLEN-1:0]      robQueryValue,
  output logic                 readDirty,
  output logic [ROB_WIDTH-1:0] readDep,
  output logic [XLEN-1:0]      readValue,
  output logic [ROB_WIDTH-1:0] robQueryTag
);

  // After reset the port looks at x0, so every output reads as zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      addrReg <= '0;
    end else begin
      addrReg <= readAddr;
    end
  end

  // The producer tag goes out unconditionally. Consumers only use it
  // when readDirty is set.
  // NOTE: every output gets a default before the if-chain, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    readDep     = regTag;
    robQueryTag = regTag;
    readDirty   = 1'b0;
    readValue   = regValue;
    if (regBusy) begin
      if (bypassHit) begin
        readValue = bypassValue;
      end else if (robQueryReady) begin
        readValue = robQueryValue;
      end else begin
        readDirty = 1'b1;
        readValue = '0;
      end
    end
  end

endmodule : rename_rf_read_port

// File: rtl/rename_reg_file.sv
// ---------------------------------------------------------------------------
// rename_reg_file
//   Architectural register file with per-register rename tracking. For each
//   register it holds:
//     - the committed value
//     - a busy bit
//     - the ROB tag of the youngest in-flight writer
//   It serves READ_PORTS registered operand lookups with ROB forwarding. It
//   also offers one combinational read for the load/store buffer. A flush
//   drops all rename state. Register x0 is hard zero and is never busy.
//
//   Optional feature: define RENAME_RF_COMMIT_BYPASS_EN to let a read port
//   take a matching commit in the same cycle. This bypass takes priority
//   over ROB forwarding.
//
// Ports
//   clockIn, resetIn            clock, asynchronous active-low reset
//   readAddr                    READ_PORTS packed register indices
//   readDirty/readDep/readValue per-port resolved operands (1-cycle latency)
//   robQueryTag                 per-port tag sent to the ROB
//   robQueryReady/robQueryValue per-port ROB forwarding answer
//   renameValid/renameDest/renameRobId   allocate a new writer
//   commitValid/commitDest/commitValue/commitRobId  retire a write
//   flush                       misprediction, clears every busy bit
//   lsbRegIndex/lsbRegValue     combinational committed-value read
// ---------------------------------------------------------------------------
module rename_reg_file
  import rv32i_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int REG_COUNT  = DEFAULT_REG_COUNT,
  parameter int ROB_WIDTH  = DEFAULT_ROB_WIDTH,
  parameter int READ_PORTS = DEFAULT_READ_PORTS,
  localparam int REG_W     = $clog2(REG_COUNT)
) (
  input  logic                            clockIn,
  input  logic                            resetIn,
  input  logic [READ_PORTS*REG_W-1:0]     readAddr,
  output logic [READ_PORTS-1:0]           readDirty,
  output logic [READ_PORTS*ROB_WIDTH-1:0] readDep,
  output logic [READ_PORTS*XLEN-1:0]      readValue,
  output logic [READ_PORTS*ROB_WIDTH-1:0] robQueryTag,
  input  logic [READ_PORTS-1:0]           robQueryReady,
  input  logic [READ_PORTS*XLEN-1:0]      robQueryValue,
  input  logic                            renameValid,
  input  logic [REG_W-1:0]                renameDest,
  input  logic [ROB_WIDTH-1:0]            renameRobId,
  input  logic                            commitValid,
  input  logic [REG_W-1:0]                commitDest,
  input  logic [XLEN-1:0]                 commitValue,
  input  logic [ROB_WIDTH-1:0]            commitRobId,
  input  logic                            flush,
  input  logic [REG_W-1:0]                lsbRegIndex,
  output logic [XLEN-1:0]                 lsbRegValue
);

  logic [XLEN-1:0]      value_q [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;

  // Per-register write enables. Entry 0 keeps all enables low, so x0
  // stays at its reset value of zero forever.
  logic [REG_COUNT-1:0] rename_hit;
  logic [REG_COUNT-1:0] commit_hit;
  logic [REG_COUNT-1:0] commit_clear;

  always_comb begin
    rename_hit   = '0;
    commit_hit   = '0;
    commit_clear = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      rename_hit[r] = renameValid && !flush && (renameDest == REG_W'(r));
      commit_hit[r] = commitValid && (commitDest == REG_W'(r));
      // Only the youngest writer may release the register. A rename to the
      // same register in this cycle creates a newer writer, so that rename
      // wins and the register stays busy.
      commit_clear[r] = commit_hit[r] && (tag_q[r] == commitRobId) && !rename_hit[r];
    end
  end

  // A commit always writes the value, even during a flush. The retired
  // result is architectural regardless of the misprediction.
  // NOTE: the whole register array is reset. Values are visible on the
  // ports straight after reset and must read as zero, so this storage is
  // flops, not an unreset RAM.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (commit_hit[r]) value_q[r] <= commitValue;
        if (rename_hit[r]) tag_q[r]   <= renameRobId;
      end
      if (flush) begin
        busy_q <= '0;
      end else begin
        busy_q <= (busy_q & ~commit_clear) | rename_hit;
      end
    end
  end

  assign lsbRegValue = value_q[lsbRegIndex];

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [REG_W-1:0] addr_reg;
    logic             bypass_hit;

`ifdef RENAME_RF_COMMIT_BYPASS_EN
    // A commit that would release this operand's register this cycle
    // supplies the operand directly.
    assign bypass_hit = commitValid && (addr_reg != '0) && (commitDest == addr_reg)
                        && busy_q[addr_reg] && (tag_q[addr_reg] == commitRobId);
`else
    assign bypass_hit = 1'b0;
`endif

    rename_rf_read_port #(
      .XLEN      (XLEN),
      .REG_W     (REG_W),
      .ROB_WIDTH (ROB_WIDTH)
    ) u_read_port (
      .clockIn       (clockIn),
      .resetIn       (resetIn),
      .readAddr      (readAddr[p*REG_W +: REG_W]),
      .addrReg       (addr_reg),
      .regBusy       (busy_q[addr_reg]),
      .regTag        (tag_q[addr_reg]),
      .regValue      (value_q[addr_reg]),
      .bypassHit     (bypass_hit),
      .bypassValue   (commitValue),
      .robQueryReady (robQueryReady[p]),
      .robQueryValue (robQueryValue[p*XLEN +: XLEN]),
      .readDirty     (readDirty[p]),
      .readDep       (readDep[p*ROB_WIDTH +: ROB_WIDTH]),
      .readValue     (readValue[p*XLEN +: XLEN]),
      .robQueryTag   (robQueryTag[p*ROB_WIDTH +: ROB_WIDTH])
    );
  end

endmodule : rename_reg_file

// File: tb/tb_rename_reg_file.sv
// ---------------------------------------------------------------------------
// tb_rename_reg_file
//   Self-checking bench for rename_reg_file in its default configuration.
//   A register-level model tracks the value, busy bit and tag of every
//   register. It also tracks the index each read port latched. The model
//   predicts every output, and the DUT is compared against it once per
//   cycle. A directed prologue pins the model with literal expectations.
//   A randomized phase follows and includes flushes and a mid-run reset.
//   Compile with +define+RENAME_RF_COMMIT_BYPASS_EN to cover the bypass
//   build.
// ---------------------------------------------------------------------------
module tb_rename_reg_file;
  import rv32i_pkg::*;

  localparam int XLEN  = DEFAULT_XLEN;
  localparam int NREG  = DEFAULT_REG_COUNT;
  localparam int RW    = DEFAULT_ROB_WIDTH;
  localparam int NP    = DEFAULT_READ_PORTS;
  localparam int REG_W = DEFAULT_REG_W;

  logic                 clockIn = 1'b0;
  logic                 resetIn;
  logic [NP*REG_W-1:0]  readAddr;
  logic [NP-1:0]        readDirty;
  logic [NP*RW-1:0]     readDep;
  logic [NP*XLEN-1:0]   readValue;
  logic [NP*RW-1:0]     robQueryTag;
  logic [NP-1:0]        robQueryReady;
  logic [NP*XLEN-1:0]   robQueryValue;
  logic                 renameValid;
  logic [REG_W-1:0]     renameDest;
  logic [RW-1:0]        renameRobId;
  logic                 commitValid;
  logic [REG_W-1:0]     commitDest;
  logic [XLEN-1:0]      commitValue;
  logic [RW-1:0]        commitRobId;
  logic                 flush;
  logic [REG_W-1:0]     lsbRegIndex;
  logic [XLEN-1:0]      lsbRegValue;

  rename_reg_file dut (
    .clockIn       (clockIn),
    .resetIn       (resetIn),
    .readAddr      (readAddr),
    .readDirty     (readDirty),
    .readDep       (readDep),
    .readValue     (readValue),
    .robQueryTag   (robQueryTag),
    .robQueryReady (robQueryReady),
    .robQueryValue (robQueryValue),
    .renameValid   (renameValid),
    .renameDest    (renameDest),
    .renameRobId   (renameRobId),
    .commitValid   (commitValid),
    .commitDest    (commitDest),
    .commitValue   (commitValue),
    .commitRobId   (commitRobId),
    .flush         (flush),
    .lsbRegIndex   (lsbRegIndex),
    .lsbRegValue   (lsbRegValue)
  );

  initial forever #5 clockIn = ~clockIn;

  // Behavioural model of the architectural state.
  logic [XLEN-1:0]  m_value [NREG];
  bit               m_busy  [NREG];
  logic [RW-1:0]    m_tag   [NREG];
  logic [REG_W-1:0] m_addr  [NP];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_value[r] = '0;
      m_busy[r]  = 1'b0;
      m_tag[r]   = '0;
    end
    for (int p = 0; p < NP; p++) m_addr[p] = '0;
  endtask

  // Apply one clock edge's worth of architectural rules.
  task automatic model_update();
    bit release_ok;
    if (!resetIn) begin
      model_reset();
      return;
    end
    release_ok = commitValid && commitDest != 0 && m_tag[commitDest] == commitRobId
                 && !(renameValid && !flush && renameDest == commitDest);
    if (commitValid && commitDest != 0) m_value[commitDest] = commitValue;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    end else begin
      if (release_ok) m_busy[commitDest] = 1'b0;
      if (renameValid && renameDest != 0) begin
        m_busy[renameDest] = 1'b1;
        m_tag[renameDest]  = renameRobId;
      end
    end
    for (int p = 0; p < NP; p++) m_addr[p] = readAddr[p*REG_W +: REG_W];
  endtask

  // Compare every output against what the model says it must be right now.
  task automatic compare_all();
    logic [REG_W-1:0] r;
    logic             e_dirty;
    logic [XLEN-1:0]  e_val;
    bit               byp;
    for (int p = 0; p < NP; p++) begin
      r = m_addr[p];
      byp = 1'b0;
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      byp = commitValid && r != 0 && commitDest == r && m_busy[r] && m_tag[r] == commitRobId;
`endif
      if (!m_busy[r]) begin
        e_dirty = 1'b0; e_val = m_value[r];
      end else if (byp) begin
        e_dirty = 1'b0; e_val = commitValue;
      end else if (robQueryReady[p]) begin
        e_dirty = 1'b0; e_val = robQueryValue[p*XLEN +: XLEN];
      end else begin
        e_dirty = 1'b1; e_val = '0;
      end
      check($sformatf("port%0d dirty", p), 64'(readDirty[p]), 64'(e_dirty));
      check($sformatf("port%0d dep", p), 64'(readDep[p*RW +: RW]), 64'(m_tag[r]));
      check($sformatf("port%0d query_tag", p), 64'(robQueryTag[p*RW +: RW]), 64'(m_tag[r]));
      check($sformatf("port%0d value", p), 64'(readValue[p*XLEN +: XLEN]), 64'(e_val));
    end
    check("lsb value", 64'(lsbRegValue), 64'(m_value[lsbRegIndex]));
  endtask

  // Entered at a falling edge with inputs driven. Compares the outputs,
  // lets the rising edge happen, updates the model, and returns at the
  // next falling edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clockIn);
    model_update();
    @(negedge clockIn);
  endtask

  task automatic idle();
    robQueryReady = '0;
    robQueryValue = '0;
    renameValid   = 1'b0;
    renameDest    = '0;
    renameRobId   = '0;
    commitValid   = 1'b0;
    commitDest    = '0;
    commitValue   = '0;
    commitRobId   = '0;
    flush         = 1'b0;
  endtask

  task automatic set_addr(input int a0, input int a1);
    readAddr = {REG_W'(a1), REG_W'(a0)};
  endtask

  initial begin
    resetIn     = 1'b0;
    lsbRegIndex = '0;
    idle();
    set_addr(5, 5);
    model_reset();

    // Reset state.
    @(negedge clockIn);
    #1;
    check("reset dirty", 64'(readDirty), 64'h0);
    check("reset value", 64'(readValue), 64'h0);
    check("reset dep", 64'(readDep), 64'h0);
    check("reset query_tag", 64'(robQueryTag), 64'h0);
    check("reset lsb", 64'(lsbRegValue), 64'h0);
    tick();
    resetIn = 1'b1;

    // Read x5 on both ports after reset.
    tick();
    #1;
    check("x5 clean dirty", 64'(readDirty), 64'h0);
    check("x5 clean value", 64'(readValue), 64'h0);
    check("x5 clean dep", 64'(readDep), 64'h0);
    tick();

    // Rename x5 -> tag 3, then read with and without ROB forwarding.
    renameValid = 1'b1; renameDest = 5; renameRobId = 3;
    tick();
    idle();
    #1;
    check("x5 busy dirty", 64'(readDirty[0]), 64'h1);
    check("x5 busy dep", 64'(readDep[3:0]), 64'h3);
    robQueryReady = 2'b11;
    robQueryValue = {32'hDEAD, 32'hDEAD};
    #1;
    check("x5 fwd dirty", 64'(readDirty[0]), 64'h0);
    check("x5 fwd value", 64'(readValue[31:0]), 64'hDEAD);
    tick();

    // Second rename x5 -> 7, then the commit of the stale tag 3.
    idle();
    renameValid = 1'b1; renameDest = 5; renameRobId = 7;
    tick();
    idle();
    commitValid = 1'b1; commitDest = 5; commitRobId = 3; commitValue = 32'h11;
    lsbRegIndex = 5;
    tick();
    idle();
    #1;
    check("x5 stale commit dirty", 64'(readDirty[0]), 64'h1);
    check("x5 stale commit dep", 64'(readDep[3:0]), 64'h7);
    check("x5 stale commit lsb", 64'(lsbRegValue), 64'h11);
    tick();

    // Same-cycle rename x6 -> 2 and commit x6 tag 1.
    set_addr(6, 6);
    renameValid = 1'b1; renameDest = 6; renameRobId = 2;
    commitValid = 1'b1; commitDest = 6; commitRobId = 1; commitValue = 32'h22;
    tick();
    idle();
    lsbRegIndex = 6;
    #1;
    check("x6 rename+commit dirty", 64'(readDirty[0]), 64'h1);
    check("x6 rename+commit dep", 64'(readDep[3:0]), 64'h2);
    check("x6 rename+commit lsb", 64'(lsbRegValue), 64'h22);
    tick();

    // Flush with a concurrent rename x7 and a commit to x8.
    set_addr(7, 6);
    flush = 1'b1;
    renameValid = 1'b1; renameDest = 7; renameRobId = 4;
    commitValid = 1'b1; commitDest = 8; commitRobId = 0; commitValue = 32'h33;
    tick();
    idle();
    lsbRegIndex = 8;
    #1;
    check("flush dirty", 64'(readDirty), 64'h0);
    check("flush x7 dep", 64'(readDep[3:0]), 64'h0);
    check("flush x6 value", 64'(readValue[63:32]), 64'h22);
    check("flush x8 lsb", 64'(lsbRegValue), 64'h33);
    tick();

    // Writes to x0 are ignored.
    set_addr(0, 0);
    renameValid = 1'b1; renameDest = 0; renameRobId = 9;
    commitValid = 1'b1; commitDest = 0; commitRobId = 0; commitValue = 32'hFF;
    tick();
    idle();
    lsbRegIndex = 0;
    robQueryReady = 2'b11;
    robQueryValue = {32'hAA, 32'hAA};
    #1;
    check("x0 dirty", 64'(readDirty), 64'h0);
    check("x0 value", 64'(readValue), 64'h0);
    check("x0 dep", 64'(readDep), 64'h0);
    check("x0 lsb", 64'(lsbRegValue), 64'h0);
    tick();

    // Commit x9 in the read cycle: same-cycle with the bypass, one later without.
    idle();
    set_addr(9, 9);
    renameValid = 1'b1; renameDest = 9; renameRobId = 5;
    tick();
    idle();
    commitValid = 1'b1; commitDest = 9; commitRobId = 5; commitValue = 32'h99;
    #1;
`ifdef RENAME_RF_COMMIT_BYPASS_EN
    check("x9 bypass dirty", 64'(readDirty[0]), 64'h0);
    check("x9 bypass value", 64'(readValue[31:0]), 64'h99);
`else
    check("x9 no-bypass dirty", 64'(readDirty[0]), 64'h1);
    check("x9 no-bypass value", 64'(readValue[31:0]), 64'h0);
`endif
    tick();
    idle();
    #1;
    check("x9 after commit dirty", 64'(readDirty[0]), 64'h0);
    check("x9 after commit value", 64'(readValue[31:0]), 64'h99);
    tick();

    // Mid-operation asynchronous reset.
    renameValid = 1'b1; renameDest = 3; renameRobId = 6;
    tick();
    idle();
    lsbRegIndex = 9;
    resetIn = 1'b0;
    model_reset();
    #1;
    check("midreset dirty", 64'(readDirty), 64'h0);
    check("midreset value", 64'(readValue), 64'h0);
    check("midreset dep", 64'(readDep), 64'h0);
    check("midreset lsb", 64'(lsbRegValue), 64'h0);
    tick();
    resetIn = 1'b1;

    // Randomized traffic over a small register window to get frequent hits.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < NP; p++) readAddr[p*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
      for (int p = 0; p < NP; p++) robQueryValue[p*XLEN +: XLEN] = XLEN'($urandom());
      robQueryReady = NP'($urandom());
      renameValid   = 1'($urandom_range(0, 1));
      renameDest    = REG_W'($urandom_range(0, 7));
      renameRobId   = RW'($urandom());
      commitValid   = 1'($urandom_range(0, 1));
      commitDest    = REG_W'($urandom_range(0, 7));
      commitValue   = XLEN'($urandom());
      commitRobId   = ($urandom_range(0, 3) != 0) ? m_tag[commitDest] : RW'($urandom());
      flush         = ($urandom_range(0, 15) == 0);
      lsbRegIndex   = REG_W'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        resetIn = 1'b0;
        model_reset();
      end else begin
        resetIn = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rename_reg_file
